// File: rtl/fb_cmd_sequencer_pkg.sv
// Shared definitions for the framebuffer command sequencer: FSM encoding,
// Y offset width and target mask bit positions.
package fb_cmd_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DRAIN     = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_t;

  localparam int Y_OFFSET_WIDTH = 12;

  localparam int TGT_COLOR = 0;
  localparam int TGT_DEPTH = 1;
  localparam int TGT_WIDTH = 2;

endpackage

// File: rtl/fb_cmd_sequencer_apply.sv
// Per-framebuffer apply pulse generator; tracks the applied falling edge (ack)
// and reports done once the framebuffer is idle again.
module fb_apply_tracker (
  input  logic clk,
  input  logic reset,
  input  logic target,
  input  logic issue,
  input  logic wait_ack,
  input  logic applied,
  output logic apply,
  output logic acked,
  output logic done
);

  logic ack_r;

  // Latch that the framebuffer has dropped applied since the last issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_r <= 1'b0;
    end else if (issue) begin
      ack_r <= 1'b0;
    end else if (wait_ack && !applied) begin
      ack_r <= 1'b1;
    end
  end

  // Apply is a single-cycle pulse: a level apply would re-trigger the framebuffer.
  assign apply = target & issue;
  assign acked = ~target | ack_r | (wait_ack & ~applied);
  assign done  = ~target | applied;

endmodule

// File: rtl/fb_cmd_sequencer.sv
// Framebuffer command sequencer: accepts one command, drains the fragment
// pipeline, pulses apply to the targeted framebuffers and waits for completion.
module fb_cmd_sequencer
  import fb_cmd_sequencer_pkg::*;
#(
  parameter int PIXEL_WIDTH = 16,
  parameter int DEPTH_WIDTH = 16,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s_cmd_valid,
  output logic                      s_cmd_ready,
  input  logic                      s_cmd_commit,
  input  logic                      s_cmd_color_memset,
  input  logic                      s_cmd_depth_memset,
  input  logic [PIXEL_WIDTH-1:0]    s_cmd_clear_color,
  input  logic [DEPTH_WIDTH-1:0]    s_cmd_clear_depth,
  input  logic [Y_OFFSET_WIDTH-1:0] s_cmd_y_offset,
  input  logic                      pipeline_idle,
  output logic                      frag_stall,
  output logic                      color_apply,
  input  logic                      color_applied,
  output logic                      color_cmd_commit,
  output logic                      color_cmd_memset,
  output logic [PIXEL_WIDTH-1:0]    color_clear,
  output logic                      depth_apply,
  input  logic                      depth_applied,
  output logic                      depth_cmd_memset,
  output logic [DEPTH_WIDTH-1:0]    depth_clear,
  output logic [Y_OFFSET_WIDTH-1:0] conf_y_offset,
  output logic                      busy,
  output logic                      err_timeout
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  state_t                  state_r, state_next;
  logic [TGT_WIDTH-1:0]    tgt_r;
  logic [CNT_W-1:0]        ack_cnt_r;
  logic                    accept_s, timeout_s;
  logic                    issue_s, wait_ack_s;
  logic                    color_acked, color_done, depth_acked, depth_done;

  assign accept_s   = (state_r == ST_IDLE) && s_cmd_valid;
  assign issue_s    = (state_r == ST_ISSUE);
  assign wait_ack_s = (state_r == ST_WAIT_ACK);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_r;
    timeout_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (s_cmd_valid) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pipeline_idle) state_next = (tgt_r == '0) ? ST_IDLE : ST_ISSUE;
      end
      ST_ISSUE: begin
        state_next = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (color_acked && depth_acked) begin
          state_next = ST_WAIT_DONE;
        end else if (ack_cnt_r + CNT_W'(1) == CNT_W'(ACK_TIMEOUT)) begin
          timeout_s  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (color_done && depth_done) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Command fields are captured once and held until the next acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      tgt_r            <= '0;
      color_cmd_commit <= 1'b0;
      color_cmd_memset <= 1'b0;
      depth_cmd_memset <= 1'b0;
      color_clear      <= '0;
      depth_clear      <= '0;
      conf_y_offset    <= '0;
    end else if (accept_s) begin
      tgt_r[TGT_COLOR] <= s_cmd_commit | s_cmd_color_memset;
      tgt_r[TGT_DEPTH] <= s_cmd_depth_memset;
      color_cmd_commit <= s_cmd_commit;
      color_cmd_memset <= s_cmd_color_memset;
      depth_cmd_memset <= s_cmd_depth_memset;
      color_clear      <= s_cmd_clear_color;
      depth_clear      <= s_cmd_clear_depth;
      conf_y_offset    <= s_cmd_y_offset;
    end
  end

  // Ack timeout counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_cnt_r   <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (issue_s) begin
        ack_cnt_r <= '0;
      end else if (wait_ack_s) begin
        ack_cnt_r <= ack_cnt_r + CNT_W'(1);
      end
      if (timeout_s) err_timeout <= 1'b1;
    end
  end

  fb_apply_tracker u_color (
    .clk      (clk),
    .reset    (reset),
    .target   (tgt_r[TGT_COLOR]),
    .issue    (issue_s),
    .wait_ack (wait_ack_s),
    .applied  (color_applied),
    .apply    (color_apply),
    .acked    (color_acked),
    .done     (color_done)
  );

  fb_apply_tracker u_depth (
    .clk      (clk),
    .reset    (reset),
    .target   (tgt_r[TGT_DEPTH]),
    .issue    (issue_s),
    .wait_ack (wait_ack_s),
    .applied  (depth_applied),
    .apply    (depth_apply),
    .acked    (depth_acked),
    .done     (depth_done)
  );

  assign s_cmd_ready = (state_r == ST_IDLE);
  assign busy        = (state_r != ST_IDLE);
  assign frag_stall  = (state_r != ST_IDLE);

endmodule

// File: tb/tb_fb_cmd_sequencer.sv
// Directed self-checking bench for fb_cmd_sequencer with simple framebuffer
// models whose busy time is programmable.
module tb_fb_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_cmd_valid = 1'b0;
  logic        s_cmd_ready;
  logic        s_cmd_commit = 1'b0, s_cmd_color_memset = 1'b0, s_cmd_depth_memset = 1'b0;
  logic [15:0] s_cmd_clear_color = 16'h0, s_cmd_clear_depth = 16'h0;
  logic [11:0] s_cmd_y_offset = 12'h0;
  logic        pipeline_idle = 1'b1;
  logic        frag_stall, color_apply, color_applied, color_cmd_commit, color_cmd_memset;
  logic [15:0] color_clear, depth_clear;
  logic        depth_apply, depth_applied, depth_cmd_memset;
  logic [11:0] conf_y_offset;
  logic        busy, err_timeout;

  int tests = 0;
  int fails = 0;

  // Framebuffer model configuration (written only by the initial block).
  int   color_n = 10, depth_n = 5;
  logic color_hang = 1'b0;

  int color_cnt, depth_cnt;
  int color_pulses = 0, depth_pulses = 0;

  fb_cmd_sequencer #(.PIXEL_WIDTH(16), .DEPTH_WIDTH(16), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .s_cmd_commit(s_cmd_commit), .s_cmd_color_memset(s_cmd_color_memset),
    .s_cmd_depth_memset(s_cmd_depth_memset),
    .s_cmd_clear_color(s_cmd_clear_color), .s_cmd_clear_depth(s_cmd_clear_depth),
    .s_cmd_y_offset(s_cmd_y_offset), .pipeline_idle(pipeline_idle),
    .frag_stall(frag_stall),
    .color_apply(color_apply), .color_applied(color_applied),
    .color_cmd_commit(color_cmd_commit), .color_cmd_memset(color_cmd_memset),
    .color_clear(color_clear),
    .depth_apply(depth_apply), .depth_applied(depth_applied),
    .depth_cmd_memset(depth_cmd_memset), .depth_clear(depth_clear),
    .conf_y_offset(conf_y_offset), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Color framebuffer model: applied low for color_n cycles after an apply.
  always @(posedge clk) begin
    if (reset) begin
      color_applied <= 1'b1;
      color_cnt     <= 0;
    end else if (color_cnt != 0) begin
      if (color_cnt == 1) color_applied <= 1'b1;
      color_cnt <= color_cnt - 1;
    end else if (color_apply && color_applied && !color_hang) begin
      color_applied <= 1'b0;
      color_cnt     <= color_n;
    end
    if (color_apply) color_pulses <= color_pulses + 1;
  end

  // Depth framebuffer model.
  always @(posedge clk) begin
    if (reset) begin
      depth_applied <= 1'b1;
      depth_cnt     <= 0;
    end else if (depth_cnt != 0) begin
      if (depth_cnt == 1) depth_applied <= 1'b1;
      depth_cnt <= depth_cnt - 1;
    end else if (depth_apply && depth_applied) begin
      depth_applied <= 1'b0;
      depth_cnt     <= depth_n;
    end
    if (depth_apply) depth_pulses <= depth_pulses + 1;
  end

  // Present one command for one cycle; returns at the negedge after acceptance.
  task automatic send_cmd(input logic c, input logic cm, input logic dm,
                          input logic [15:0] cc, input logic [15:0] cd, input logic [11:0] y);
    @(negedge clk);
    tests++;
    if (s_cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_ready: got %b want 1", s_cmd_ready);
    end
    s_cmd_valid = 1'b1; s_cmd_commit = c; s_cmd_color_memset = cm; s_cmd_depth_memset = dm;
    s_cmd_clear_color = cc; s_cmd_clear_depth = cd; s_cmd_y_offset = y;
    @(negedge clk);
    s_cmd_valid = 1'b0; s_cmd_commit = 1'b0; s_cmd_color_memset = 1'b0;
    s_cmd_depth_memset = 1'b0; s_cmd_clear_color = 16'h0; s_cmd_clear_depth = 16'h0;
    s_cmd_y_offset = 12'h0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({s_cmd_ready, busy, frag_stall, color_apply, depth_apply, err_timeout} !== 6'b100000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 100000",
               {s_cmd_ready, busy, frag_stall, color_apply, depth_apply, err_timeout});
    end
    tests++;
    if ({color_cmd_commit, color_cmd_memset, depth_cmd_memset, color_clear, depth_clear, conf_y_offset} !== 47'h0) begin
      fails++;
      $display("FAIL reset_data: got %h want 0",
               {color_cmd_commit, color_cmd_memset, depth_cmd_memset, color_clear, depth_clear, conf_y_offset});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_commit;
    int n = 0, cp, dp, bad = 0;
    color_n = 10;
    cp = color_pulses; dp = depth_pulses;
    send_cmd(1'b1, 1'b0, 1'b0, 16'h1234, 16'h0, 12'd48);
    while (!s_cmd_ready && n < 60) begin
      if (conf_y_offset !== 12'd48 || depth_apply !== 1'b0 || frag_stall !== 1'b1 || busy !== 1'b1) bad++;
      @(negedge clk); n++;
    end
    tests++;
    if (n !== 13) begin fails++; $display("FAIL commit_latency: got %0d want 13", n); end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL commit_hold: got %0d bad cycles want 0", bad); end
    tests++;
    if (color_pulses - cp !== 1 || depth_pulses - dp !== 0) begin
      fails++;
      $display("FAIL commit_pulses: got c=%0d d=%0d want c=1 d=0", color_pulses - cp, depth_pulses - dp);
    end
    tests++;
    if (color_applied !== 1'b1 || color_cmd_commit !== 1'b1 || color_cmd_memset !== 1'b0) begin
      fails++;
      $display("FAIL commit_end: got applied=%b commit=%b memset=%b want 1 1 0",
               color_applied, color_cmd_commit, color_cmd_memset);
    end
  endtask

  task automatic test_memset_both;
    int n = 0, cp, dp, bad_clr = 0, bad_sync = 0;
    color_n = 20; depth_n = 5;
    cp = color_pulses; dp = depth_pulses;
    send_cmd(1'b0, 1'b1, 1'b1, 16'hF00F, 16'hFFFF, 12'd7);
    while (!s_cmd_ready && n < 60) begin
      if (color_clear !== 16'hF00F || depth_clear !== 16'hFFFF) bad_clr++;
      if (color_apply !== depth_apply) bad_sync++;
      @(negedge clk); n++;
    end
    tests++;
    if (n !== 23) begin fails++; $display("FAIL memset_latency: got %0d want 23", n); end
    tests++;
    if (bad_clr !== 0) begin fails++; $display("FAIL memset_clear_hold: got %0d bad cycles want 0", bad_clr); end
    tests++;
    if (bad_sync !== 0 || color_pulses - cp !== 1 || depth_pulses - dp !== 1) begin
      fails++;
      $display("FAIL memset_pulses: got sync_bad=%0d c=%0d d=%0d want 0 1 1",
               bad_sync, color_pulses - cp, depth_pulses - dp);
    end
    tests++;
    if ({color_cmd_commit, color_cmd_memset, depth_cmd_memset} !== 3'b011) begin
      fails++;
      $display("FAIL memset_bits: got %b want 011", {color_cmd_commit, color_cmd_memset, depth_cmd_memset});
    end
  endtask

  task automatic test_drain;
    int n = 0, bad = 0, cp;
    color_n = 2;
    cp = color_pulses;
    pipeline_idle = 1'b0;
    send_cmd(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 12'd5);
    for (int i = 0; i < 7; i++) begin
      if (frag_stall !== 1'b1 || color_apply !== 1'b0) bad++;
      @(negedge clk);
    end
    pipeline_idle = 1'b1;
    if (frag_stall !== 1'b1 || color_apply !== 1'b0) bad++;
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL drain_hold: got %0d bad cycles want 0", bad); end
    @(negedge clk);
    tests++;
    if (color_apply !== 1'b1 || frag_stall !== 1'b1) begin
      fails++;
      $display("FAIL drain_issue: got apply=%b stall=%b want 1 1", color_apply, frag_stall);
    end
    while (!s_cmd_ready && n < 60) begin @(negedge clk); n++; end
    tests++;
    if (!s_cmd_ready || color_pulses - cp !== 1) begin
      fails++;
      $display("FAIL drain_done: got ready=%b pulses=%0d want 1 1", s_cmd_ready, color_pulses - cp);
    end
  endtask

  task automatic test_empty;
    int cp, dp;
    cp = color_pulses; dp = depth_pulses;
    send_cmd(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 12'd0);
    tests++;
    if (s_cmd_ready !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL empty_busy: got ready=%b busy=%b want 0 1", s_cmd_ready, busy);
    end
    @(negedge clk);
    tests++;
    if (s_cmd_ready !== 1'b1 || busy !== 1'b0 || color_pulses - cp !== 0 || depth_pulses - dp !== 0) begin
      fails++;
      $display("FAIL empty_done: got ready=%b busy=%b c=%0d d=%0d want 1 0 0 0",
               s_cmd_ready, busy, color_pulses - cp, depth_pulses - dp);
    end
  endtask

  task automatic test_timeout;
    int bad = 0, n = 0;
    color_hang = 1'b1;
    send_cmd(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 12'd1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (err_timeout !== 1'b0 || s_cmd_ready !== 1'b0) bad++;
    end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL timeout_early: got %0d bad cycles want 0", bad); end
    @(negedge clk);
    tests++;
    if (err_timeout !== 1'b1 || s_cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL timeout_flag: got err=%b ready=%b want 1 1", err_timeout, s_cmd_ready);
    end
    color_hang = 1'b0; color_n = 3;
    send_cmd(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 12'd2);
    while (!s_cmd_ready && n < 60) begin @(negedge clk); n++; end
    tests++;
    if (n !== 6 || err_timeout !== 1'b1) begin
      fails++;
      $display("FAIL timeout_recover: got latency=%0d err=%b want 6 1", n, err_timeout);
    end
  endtask

  task automatic test_reset_mid;
    color_n = 10;
    send_cmd(1'b1, 1'b0, 1'b0, 16'hABCD, 16'h0, 12'd9);
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b1 || color_applied !== 1'b0) begin
      fails++;
      $display("FAIL midreset_pre: got busy=%b applied=%b want 1 0", busy, color_applied);
    end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({s_cmd_ready, busy, frag_stall, color_apply, depth_apply, err_timeout, conf_y_offset} !== {6'b100000, 12'd0}) begin
      fails++;
      $display("FAIL midreset: got %b want 100000 y=0",
               {s_cmd_ready, busy, frag_stall, color_apply, depth_apply, err_timeout, conf_y_offset});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_commit();
    test_memset_both();
    test_drain();
    test_empty();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
